// File: rtl/cntr_modulus_down.sv
// Modulus-N down-counter: counts MOD_VAL-1 .. 0 and wraps, or halts at 0 in one-shot mode.
// at_zero is the cascade borrow; wrap and halted are registered status flags.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   RUN   | counting down; at 0 either wraps (oneshot=0) or halts
//   HALT  | parked at q=0; leaves on load, or on a count with oneshot=0
module cntr_modulus_down #(
   parameter int WIDTH   = 16,
   parameter int MOD_VAL = 50223
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             sclear,
   input  logic             sload,
   input  logic [WIDTH-1:0] sdata,
   input  logic             oneshot,
   output logic [WIDTH-1:0] q,
   output logic             at_zero,
   output logic             wrap,
   output logic             halted
);

   typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

   localparam logic [WIDTH-1:0] TOP     = WIDTH'(MOD_VAL - 1);
   // One extra bit so MOD_VAL == 2**WIDTH still compares correctly.
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD_VAL);

   state_t           state;
   logic [WIDTH-1:0] load_val;

   assign load_val = ({1'b0, sdata} < MOD_EXT) ? sdata : TOP;
   assign at_zero  = (q == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         q      <= TOP;
         state  <= RUN;
         wrap   <= 1'b0;
         halted <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (ena) begin
            if (sclear) begin
               q      <= '0;
               state  <= oneshot ? HALT : RUN;
               halted <= oneshot;
            end else if (sload) begin
               q      <= load_val;
               state  <= RUN;
               halted <= 1'b0;
            end else begin
               case (state)
                  RUN: begin
                     if (q != '0) begin
                        q <= q - WIDTH'(1);
                     end else if (oneshot) begin
                        state  <= HALT;
                        halted <= 1'b1;
                     end else begin
                        q    <= TOP;
                        wrap <= 1'b1;
                     end
                  end
                  HALT: begin
                     // HALT is only ever entered with q at 0, so holding q needs no action.
                     if (!oneshot) begin
                        q      <= TOP;
                        state  <= RUN;
                        halted <= 1'b0;
                        wrap   <= 1'b1;
                     end
                  end
                  default: begin
                     state  <= RUN;
                     halted <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: doc/cntr_modulus_down.md
Name: cntr_modulus_down

Overview:
- Modulus-N down-counter. It is the descending companion to the team's modulus up-counter.
- Counts MOD_VAL-1 down to 0, then wraps back to MOD_VAL-1.
- Supports a one-shot mode that halts at 0 instead of wrapping.
- Used for countdown timers, reload dividers and cascaded prescalers. The zero and wrap flags feed downstream stages or a status block.

Parameters:
- WIDTH, 16, counter width in bits. Must satisfy 2^WIDTH >= MOD_VAL.
- MOD_VAL, 50223, modulus. Counting range is 0 to MOD_VAL-1. MOD_VAL >= 2.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-high.
- ena  input  1  clock enable; gates sclear, sload and counting.
- sclear  input  1  synchronous clear; q goes to 0.
- sload  input  1  synchronous load of sdata (clamped).
- sdata  input  WIDTH  load value.
- oneshot  input  1  1 = halt at 0 instead of wrapping; sampled every cycle.
- q  output  WIDTH  counter value, registered.
- at_zero  output  1  combinational (q == 0); cascade borrow to the next stage's ena.
- wrap  output  1  registered; one-cycle pulse after a 0 -> MOD_VAL-1 transition.
- halted  output  1  registered; 1 while the state machine is in HALT.

Behaviour:
- Reset (rst=1 at a clock edge):
  - q = MOD_VAL-1, state = RUN, wrap = 0, halted = 0.
  - rst overrides all other inputs.
- State machine with two states, RUN and HALT; halted = (state == HALT).
- Priority at each edge: rst, then ena, then sclear, then sload, then count.
- ena=0:
  - q and state hold.
  - wrap = 0.
- ena=1, sclear=1:
  - q = 0.
  - State = HALT if oneshot=1, else RUN.
  - wrap = 0.
- ena=1, sload=1, sclear=0:
  - q = sdata if sdata < MOD_VAL, else q = MOD_VAL-1 (clamp).
  - State = RUN, wrap = 0.
  - Loading 0 with oneshot=1 enters RUN. The next enabled count then halts.
- ena=1, count, state RUN:
  - q != 0: q = q-1, wrap = 0.
  - q == 0 and oneshot=0: q = MOD_VAL-1, wrap = 1 for exactly the next cycle.
  - q == 0 and oneshot=1: q holds 0, state = HALT, wrap = 0.
- ena=1, count, state HALT:
  - oneshot=1: q holds 0, state stays HALT.
  - oneshot=0: q = MOD_VAL-1, state = RUN, wrap = 1.
  - This allows resuming periodic operation.
- Latency:
  - q, wrap and halted update on the same edge that samples the inputs.
  - at_zero follows q with no extra delay.
- Arithmetic:
  - Decrement is modulo the range; q never leaves 0..MOD_VAL-1 after reset.
  - The clamp compare is unsigned, over the full WIDTH.
- Cascade rules:
  - Drive the next stage's ena with (at_zero & this stage's ena).
  - wrap must not assert on load or clear, even when the value moves to MOD_VAL-1 via sload.
- Simultaneous events:
  - sclear and sload together: sclear wins.
  - rst with any input: reset wins.
  - oneshot toggling mid-count has no effect until q == 0 or the block is in HALT.
- Implementation budget: about one logic cell per bit for the datapath, plus a single state flop.

Test Plan:
1. Periodic wrap, MOD_VAL=5, oneshot=0, ena=1 after reset -> q sequence 4,3,2,1,0,4,3; wrap=1 only in the cycle q first shows the second 4; at_zero=1 only while q=0.
2. One-shot halt, MOD_VAL=5, oneshot=1 -> q sequence 4,3,2,1,0,0,0; halted=1 from the cycle after q first reaches 0; wrap never asserts. Then drop oneshot -> q=4, halted=0, wrap=1.
3. Load and clamp, MOD_VAL=5:
   - sload with sdata=3 -> q=3 next cycle, then 2.
   - sload with sdata=9 -> q=4 and wrap=0.
   - sclear and sload together with sdata=2 -> q=0.
4. Enable gating, MOD_VAL=5, q=2, ena=0 for 3 cycles with sclear=1 and sload=1 pulsed -> q stays 2 and wrap=0; on ena=1 -> q=1.
5. Reset mid-operation, MOD_VAL=5, in HALT (q=0, halted=1), pulse rst one cycle -> q=4, halted=0, wrap=0 on the next edge, then counting resumes as 3.
6. Cascade, two instances WIDTH=4, MOD_VAL=3, stage-2 ena = stage-1 at_zero & ena -> stage 2 decrements once every 3 cycles; combined state cycles through all 9 values; stage-2 wrap fires once per 9 cycles.
